// File: rtl/io_pkg.sv
// Shared definitions for the IO page: register offsets, status bit layout,
// and the UART serializer state encoding.
package io_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [1:0] REG_LEDS        = 2'd0;
  localparam logic [1:0] REG_UART_DATA   = 2'd1;
  localparam logic [1:0] REG_UART_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD_DIV    = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } serState_t;

  // Assemble the UART_STATUS read word; unused bits stay zero.
  function automatic logic [31:0] packStatus(input logic busy, input logic full,
                                             input logic ovf, input logic [4:0] cnt);
    logic [31:0] word;
    word = '0;
    word[STAT_BUSY] = busy;
    word[STAT_FULL] = full;
    word[STAT_OVF]  = ovf;
    word[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first. Takes bytes over a valid/ready handshake
// and can accept the next byte on the last cycle of STOP so frames run
// back-to-back without an idle gap.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SER_IDLE  | line high, ready for a byte; accepting one starts a frame
// SER_START | start bit (low) for BAUD_DIV cycles
// SER_DATA  | data bits 0..7, BAUD_DIV cycles each
// SER_STOP  | stop bit (high); on its last cycle accept next byte or idle
module uart_tx_serializer
  import io_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txByte,
  input  logic       txValid,
  output logic       txReady,
  output logic       busy,
  output logic       uart_txd
);

  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

  serState_t   state;
  serState_t   stateNext;
  logic [15:0] baudCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic        txdReg;
  logic        txdNext;
  logic        bitDone;
  logic        loadByte;
  logic        shiftNow;

  assign bitDone  = (baudCnt == BIT_LAST);
  assign busy     = (state != SER_IDLE);
  assign uart_txd = txdReg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SER_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, handshake and next line level.
  always_comb begin
    stateNext = state;
    txdNext   = txdReg;
    txReady   = 1'b0;
    loadByte  = 1'b0;
    shiftNow  = 1'b0;
    case (state)
      SER_IDLE: begin
        txReady = 1'b1;
        txdNext = 1'b1;
        if (txValid) begin
          stateNext = SER_START;
          loadByte  = 1'b1;
          txdNext   = 1'b0;
        end
      end
      SER_START: begin
        if (bitDone) begin
          stateNext = SER_DATA;
          txdNext   = shiftReg[0];
        end
      end
      SER_DATA: begin
        if (bitDone) begin
          shiftNow = 1'b1;
          if (bitIdx == 3'd7) begin
            stateNext = SER_STOP;
            txdNext   = 1'b1;
          end else begin
            txdNext = shiftReg[1];
          end
        end
      end
      SER_STOP: begin
        txReady = bitDone;
        if (bitDone) begin
          if (txValid) begin
            stateNext = SER_START;
            loadByte  = 1'b1;
            txdNext   = 1'b0;
          end else begin
            stateNext = SER_IDLE;
            txdNext   = 1'b1;
          end
        end
      end
      default: begin
        stateNext = SER_IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  // Bit timer, bit index, shift register and registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txdReg   <= 1'b1;
    end else begin
      txdReg <= txdNext;
      if (state == SER_IDLE || bitDone) begin
        baudCnt <= '0;
      end else begin
        baudCnt <= baudCnt + 16'd1;
      end
      // Index wraps 7 -> 0 as the last data bit completes.
      if (shiftNow) begin
        bitIdx <= bitIdx + 3'd1;
      end else if (state != SER_DATA) begin
        bitIdx <= '0;
      end
      if (loadByte) begin
        shiftReg <= txByte;
      end else if (shiftNow) begin
        shiftReg <= {1'b0, shiftReg[7:1]};
      end
    end
  end

endmodule

// File: rtl/io_uart_responder.sv
// Memory-mapped IO page: LED register, UART TX FIFO with status/overflow
// reporting, and a read-only baud divisor. Feeds uart_tx_serializer.
module io_uart_responder
  import io_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [7:0]  LEDS,
  output logic        uart_txd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic             overflow;

  logic       pageSel;
  logic [1:0] regSel;
  logic       pushReq;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       push;
  logic       drop;
  logic       pop;
  logic       ovfClear;
  logic       txValid;
  logic       txReady;
  logic       serBusy;
  logic [4:0] countField;
  logic       unusedBits;

  assign pageSel   = IO_mem_addr[IO_PAGE_BIT];
  assign regSel    = IO_mem_addr[3:2];
  assign fifoFull  = (fifoCount == DEPTH_C);
  assign fifoEmpty = (fifoCount == '0);

  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // never makes room for a push into a full FIFO.
  assign pushReq  = IO_mem_wr && pageSel && (regSel == REG_UART_DATA);
  assign push     = pushReq && !fifoFull;
  assign drop     = pushReq && fifoFull;
  assign ovfClear = IO_mem_wr && pageSel && (regSel == REG_UART_STATUS) && IO_mem_wdata[STAT_OVF];

  assign txValid    = !fifoEmpty;
  assign pop        = txValid && txReady;
  assign countField = 5'(fifoCount);

  assign unusedBits = ^{IO_mem_addr[31:23], IO_mem_addr[21:4], IO_mem_addr[1:0],
                        IO_mem_wdata[31:8]};

  // LED register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LEDS <= '0;
    end else if (IO_mem_wr && pageSel && (regSel == REG_LEDS)) begin
      LEDS <= IO_mem_wdata[7:0];
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= IO_mem_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifoCount <= fifoCount + CNT_W'(1);
      end else if (pop && !push) begin
        fifoCount <= fifoCount - CNT_W'(1);
      end
    end
  end

  // Sticky overflow flag; a drop on the clearing edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovfClear) begin
      overflow <= 1'b0;
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    IO_mem_rdata = '0;
    if (pageSel) begin
      case (regSel)
        REG_LEDS:        IO_mem_rdata = {24'b0, LEDS};
        REG_UART_DATA:   IO_mem_rdata = '0;
        REG_UART_STATUS: IO_mem_rdata = packStatus(serBusy || !fifoEmpty, fifoFull,
                                                   overflow, countField);
        REG_BAUD_DIV:    IO_mem_rdata = 32'(BAUD_DIV);
        default:         IO_mem_rdata = '0;
      endcase
    end
  end

  uart_tx_serializer #(
    .BAUD_DIV(BAUD_DIV)
  ) serializer (
    .clk      (clk),
    .reset    (reset),
    .txByte   (fifoMem[rdPtr]),
    .txValid  (txValid),
    .txReady  (txReady),
    .busy     (serBusy),
    .uart_txd (uart_txd)
  );

endmodule

// File: doc/io_uart_responder.md
IO_UART_RESPONDER -- requirements
Module: io_uart_responder

Interface
REQ-001 Parameter BAUD_DIV, default 434, sets clk cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, sets TX FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IO_mem_addr  input  32  byte address from the processor; bit 22 selects the IO page, bits [3:2] select the register.
REQ-006 IO_mem_wdata  input  32  write data, sampled on the same edge as IO_mem_wr.
REQ-007 IO_mem_wr  input  1  single-cycle write strobe.
REQ-008 IO_mem_rdata  output  32  read data, combinational from IO_mem_addr and current state.
REQ-009 LEDS  output  8  LED register contents.
REQ-010 uart_txd  output  1  serial transmit line, idle high.

Function
REQ-011 The block is selected only when IO_mem_addr[22]=1; writes with bit 22 clear are ignored, and IO_mem_rdata is 0 when bit 22 is clear.
REQ-012 Register map by IO_mem_addr[3:2]: 0 LEDS (R/W), 1 UART_DATA (W), 2 UART_STATUS (R/W1C), 3 BAUD_DIV (R).
REQ-013 Write to LEDS latches IO_mem_wdata[7:0] on that edge; reads return {24'b0, LEDS}.
REQ-014 Write to UART_DATA pushes IO_mem_wdata[7:0] into the FIFO when the pre-edge count < FIFO_DEPTH; otherwise data is dropped and the overflow flag sets.
REQ-015 Fullness uses the pre-edge count: a push on the same edge as a pop from a full FIFO is still dropped.
REQ-016 A push and a pop on the same edge from a non-full, non-empty FIFO leave the count unchanged.
REQ-017 UART_STATUS read: bit0 busy (serializer not IDLE, or FIFO not empty), bit1 FIFO full, bit2 overflow (sticky), bits[8:4] FIFO count, all other bits 0.
REQ-018 Writing UART_STATUS with wdata[2]=1 clears overflow; if an overflow event occurs on the same edge, set wins.
REQ-019 Reads of UART_DATA return 0; BAUD_DIV reads return the parameter zero-extended; reads have no side effects.
REQ-020 Serializer FSM has states IDLE, START, DATA, STOP; in IDLE with the FIFO not empty, it pops one byte and enters START on the same edge.
REQ-021 Frame format is 8N1, LSB first: START drives 0, DATA drives bits 0..7, STOP drives 1, each bit held exactly BAUD_DIV cycles; uart_txd is registered.
REQ-022 A UART_DATA write at edge N into an empty FIFO with an IDLE serializer produces start-bit low from edge N+1; the frame lasts 10*BAUD_DIV cycles.
REQ-023 At the end of STOP, the FSM pops the next byte with no idle gap if the FIFO is not empty; otherwise it returns to IDLE.
REQ-024 The bit-period counter and the bit index wrap to 0 on each bit and frame boundary; no counter overflows for any legal BAUD_DIV.

Reset
REQ-025 While reset=1, outputs are: LEDS=0, uart_txd=1, FIFO count=0, overflow=0, FSM=IDLE, and all counters 0, applied immediately regardless of clk.
REQ-026 Reset asserted mid-frame aborts the frame: uart_txd returns high asynchronously, and queued bytes are discarded.
REQ-027 After reset deasserts, the first UART_DATA write behaves per REQ-022.

Structure
REQ-028 Package io_pkg holds the register offsets, STATUS bit positions, and the serializer state enum.
REQ-029 The serializer is a sub-module uart_tx_serializer (byte/valid/ready in, uart_txd out); the FIFO and register decode stay in the top module.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-030 Write 0x400000 wdata 0xA5 -> LEDS=0xA5 next cycle; read 0x400000 returns 0x000000A5; write to 0x000000 leaves LEDS unchanged.
REQ-031 Write 0x400004 wdata 0x55 at edge N -> uart_txd low for edges N+1..N+4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high; STATUS bit0=0 after 40 cycles.
REQ-032 Write six bytes on consecutive cycles -> the first is popped at once, four are queued, the sixth is dropped; STATUS reads full=1, overflow=1, count=4; five frames of 40 cycles each transmit back-to-back with no gap.
REQ-033 Write STATUS with 0x4 -> overflow clears; the same write coinciding with a dropped push -> overflow stays 1.
REQ-034 Assert reset at cycle 15 of a frame -> uart_txd=1 within the same cycle, and STATUS reads 0 after release.
REQ-035 Read 0x40000C -> returns 4; read 0x400004 -> returns 0.
